// File: rtl/prefix_pkg.sv
// prefix_pkg: shared generate/propagate type, width limit and prefix combine operator
package prefix_pkg;
  localparam int MAX_WIDTH = 64;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  function automatic gp_t gp_combine(gp_t hi, gp_t lo);
    return '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
  endfunction
endpackage

// File: rtl/prefix_cell.sv
// prefix_cell: Kogge-Stone black cell merging a higher and a lower (g,p) group
module prefix_cell
  import prefix_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t res
);
  assign res = gp_combine(hi, lo);
endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: registered Kogge-Stone adder with valid/ready stall; PREFIX_ADDER_SUB_EN adds in_sub (a - b)
module pipelined_prefix_adder
  import prefix_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PREFIX_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int LAT = LEVELS + 1;

  if (WIDTH < 4 || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_prefix_adder: WIDTH must be a power of two in 4..64");
  end

  logic [WIDTH-1:0] beff;
  logic             ceff;
`ifdef PREFIX_ADDER_SUB_EN
  assign beff = in_sub ? ~b : b;
  assign ceff = cin ^ in_sub;
`else
  assign beff = b;
  assign ceff = cin;
`endif

  // Stage k holds the (g,p) of positions 0..WIDTH; position 0 is bit -1 carrying the carry-in.
  gp_t  [WIDTH:0]   gp_d [LAT];
  gp_t  [WIDTH:0]   gp_q [LAT];
  logic [WIDTH-1:0] x_q  [LAT];
  logic [LAT-1:0]   v_q, am_q, bm_q;

  assign gp_d[0][0] = '{g: ceff, p: 1'b0};
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign gp_d[0][i+1] = '{g: a[i] & beff[i], p: a[i] ^ beff[i]};
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
      if (j >= (1 << (k - 1))) begin : g_cell
        prefix_cell u_cell (
          .hi (gp_q[k-1][j]),
          .lo (gp_q[k-1][j-(1<<(k-1))]),
          .res(gp_d[k][j])
        );
      end else begin : g_pass
        assign gp_d[k][j] = gp_q[k-1][j];
      end
    end
  end

  // After LEVELS levels every position below WIDTH already reaches bit -1; the top
  // position still lacks it, so each group is closed against position 0 (a no-op for
  // the complete ones, including position 0 combined with itself).
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  for (genvar j = 0; j <= WIDTH; j++) begin : g_close
    assign carry[j] = gp_q[LEVELS][j].g | (gp_q[LEVELS][j].p & gp_q[LEVELS][0].g);
  end
  assign sum_d = x_q[LEVELS] ^ carry[WIDTH-1:0];

  assign in_ready = ~(out_valid & ~out_ready);

  // Advance the whole pipe, bubbles included, unless the result is being held back
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v_q       <= '0;
      am_q      <= '0;
      bm_q      <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        gp_q[k] <= '0;
        x_q[k]  <= '0;
      end
    end else if (in_ready) begin
      v_q       <= {v_q[LAT-2:0], in_valid};
      am_q      <= {am_q[LAT-2:0], a[WIDTH-1]};
      bm_q      <= {bm_q[LAT-2:0], beff[WIDTH-1]};
      x_q[0]    <= a ^ beff;
      out_valid <= v_q[LAT-1];
      sum       <= sum_d;
      cout      <= carry[WIDTH];
      overflow  <= (am_q[LAT-1] == bm_q[LAT-1]) & (sum_d[WIDTH-1] != am_q[LAT-1]);
      for (int k = 0; k < LAT; k++) gp_q[k] <= gp_d[k];
      for (int k = 1; k < LAT; k++) x_q[k] <= x_q[k-1];
    end
endmodule
